// File: rtl/qspi_flash_arbiter_if.sv
// Signal bundle between the two QSPI masters, the arbiter and the flash pad logic.
// The arbiter takes the slave side; the board top (or a bench) drives the master side.
interface qspi_flash_arbiter_if;
   logic       req0, gnt0, sclk0, cs_n0;
   logic [3:0] qdo0, oe0, qdi0;
   logic       req1, gnt1, sclk1, cs_n1;
   logic [3:0] qdo1, oe1, qdi1;
   logic [3:0] qdi;
   logic       spi_sclk, spi_csn;
   logic [3:0] qdo, oe;
   logic [1:0] owner;
   logic       fault;

   modport slave (
      input  req0, sclk0, cs_n0, qdo0, oe0,
      input  req1, sclk1, cs_n1, qdo1, oe1,
      input  qdi,
      output gnt0, gnt1, qdi0, qdi1,
      output spi_sclk, spi_csn, qdo, oe, owner, fault
   );

   modport master (
      output req0, sclk0, cs_n0, qdo0, oe0,
      output req1, sclk1, cs_n1, qdo1, oe1,
      output qdi,
      input  gnt0, gnt1, qdi0, qdi1,
      input  spi_sclk, spi_csn, qdo, oe, owner, fault
   );
endinterface

// File: rtl/qspi_flash_arbiter.sv
// Round-robin arbiter sharing one QSPI flash between two masters, frame-granular with a deselect guard.
// Define SPI_ARB_TIMEOUT_EN to bound ownership to TIMEOUT_CYCLES clocks and raise a sticky fault.
module qspi_flash_arbiter #(
   parameter int unsigned GUARD_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic                 clk,
   input  logic                 rst,
   qspi_flash_arbiter_if.slave  bus
);

   if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard
      $error("GUARD_CYCLES must be 1..255");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 2097151) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must fit the 21-bit hold counter");
   end

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_e;

   localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

   state_e     state_q, state_d;
   logic       rr_q, rr_d;            // port that wins the next tie
   logic [7:0] guard_cnt_q, guard_cnt_d;
   logic       fault_q, fault_d;
   logic       owned, own_req, own_csn, timeout;

   assign owned   = (state_q == OWN0) || (state_q == OWN1);
   assign own_req = (state_q == OWN1) ? bus.req1  : bus.req0;
   assign own_csn = (state_q == OWN1) ? bus.cs_n1 : bus.cs_n0;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam logic [20:0] HOLD_LAST = 21'(TIMEOUT_CYCLES - 1);
   logic [20:0] hold_cnt_q, hold_cnt_d;

   // Zero outside ownership, so it is already clear on the first owned clock.
   assign hold_cnt_d = owned ? hold_cnt_q + 21'd1 : '0;
   assign timeout    = owned && (hold_cnt_q == HOLD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hold_cnt_q <= '0;
      else     hold_cnt_q <= hold_cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_q        <= 1'b0;
         guard_cnt_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         guard_cnt_q <= guard_cnt_d;
         fault_q     <= fault_d;
      end
   end

   // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      guard_cnt_d = guard_cnt_q;
      fault_d     = fault_q;
      case (state_q)
         IDLE: begin
            if (bus.req0 && (!bus.req1 || !rr_q)) begin
               state_d = OWN0;
               rr_d    = 1'b1;
            end else if (bus.req1) begin
               state_d = OWN1;
               rr_d    = 1'b0;
            end
         end
         OWN0, OWN1: begin
            if (timeout) begin
               state_d     = GUARD;
               guard_cnt_d = GUARD_LOAD;
               fault_d     = 1'b1;
            end else if (!own_req && own_csn) begin
               state_d     = GUARD;
               guard_cnt_d = GUARD_LOAD;
            end
         end
         GUARD: begin
            if (guard_cnt_q == 8'd0) state_d = IDLE;
            else                     guard_cnt_d = guard_cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pads follow the registered owner combinationally, so the SPI path adds no latency.
   always_comb begin
      bus.gnt0     = 1'b0;
      bus.gnt1     = 1'b0;
      bus.owner    = 2'b00;
      bus.spi_sclk = 1'b0;
      bus.spi_csn  = 1'b1;
      bus.qdo      = 4'h0;
      bus.oe       = 4'h0;
      case (state_q)
         OWN0: begin
            bus.gnt0     = 1'b1;
            bus.owner    = 2'b01;
            bus.spi_sclk = bus.sclk0;
            bus.spi_csn  = bus.cs_n0;
            bus.qdo      = bus.qdo0;
            bus.oe       = bus.oe0;
         end
         OWN1: begin
            bus.gnt1     = 1'b1;
            bus.owner    = 2'b10;
            bus.spi_sclk = bus.sclk1;
            bus.spi_csn  = bus.cs_n1;
            bus.qdo      = bus.qdo1;
            bus.oe       = bus.oe1;
         end
         default: ;
      endcase
   end

   assign bus.qdi0  = bus.qdi;
   assign bus.qdi1  = bus.qdi;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// Scoreboard bench for qspi_flash_arbiter: a cycle-level reference model predicts every
// visible output; directed scenarios are followed by a long randomized run.
module tb_qspi_flash_arbiter;

   localparam int GUARD = 4;
   localparam int TMO   = 100;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   typedef struct packed {
      logic       gnt0, gnt1;
      logic [1:0] owner;
      logic       spi_sclk, spi_csn;
      logic [3:0] qdo, oe, qdi0, qdi1;
      logic       fault;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qspi_flash_arbiter_if bus ();

   qspi_flash_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
   endtask

   // Staged stimulus, applied just after each rising edge.
   logic       s_rst;
   logic       s_req  [2];
   logic       s_sclk [2];
   logic       s_csn  [2];
   logic [3:0] s_qdo  [2];
   logic [3:0] s_oe   [2];
   logic [3:0] s_qdi;

   // Reference model: who owns the flash, how long the guard still lasts, who wins a tie.
   int m_owner;       // 0 none, 1 port 0, 2 port 1
   int m_guard_left;
   int m_pref;
   int m_hold;
   bit m_fault;
   int winner;
   logic own_req, own_csn;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = 0; m_guard_left = 0; m_pref = 0; m_hold = 0; m_fault = 1'b0;
      end else if (m_owner != 0) begin
         m_hold++;
         own_req = (m_owner == 1) ? bus.req0  : bus.req1;
         own_csn = (m_owner == 1) ? bus.cs_n0 : bus.cs_n1;
         if (TIMEOUT_ON && m_hold == TMO) begin
            m_fault = 1'b1; m_owner = 0; m_guard_left = GUARD;
         end else if (!own_req && own_csn) begin
            m_owner = 0; m_guard_left = GUARD;
         end
      end else if (m_guard_left > 0) begin
         m_guard_left--;
      end else if (bus.req0 || bus.req1) begin
         winner    = (bus.req0 && bus.req1) ? m_pref : (bus.req0 ? 0 : 1);
         m_owner   = winner + 1;
         m_pref    = 1 - winner;
         m_hold    = 0;
      end
   end

   function automatic obs_t expect_now();
      obs_t e;
      e         = '0;
      e.spi_csn = 1'b1;
      e.qdi0    = bus.qdi;
      e.qdi1    = bus.qdi;
      e.fault   = m_fault;
      if (m_owner == 1) begin
         e.gnt0 = 1'b1; e.owner = 2'b01;
         e.spi_sclk = bus.sclk0; e.spi_csn = bus.cs_n0; e.qdo = bus.qdo0; e.oe = bus.oe0;
      end else if (m_owner == 2) begin
         e.gnt1 = 1'b1; e.owner = 2'b10;
         e.spi_sclk = bus.sclk1; e.spi_csn = bus.cs_n1; e.qdo = bus.qdo1; e.oe = bus.oe1;
      end
      return e;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o = {bus.gnt0, bus.gnt1, bus.owner, bus.spi_sclk, bus.spi_csn,
           bus.qdo, bus.oe, bus.qdi0, bus.qdi1, bus.fault};
      return o;
   endfunction

   obs_t sb[$];
   obs_t mon_exp;

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_exp = sb.pop_front();
         check("scoreboard", 32'(observe()), 32'(mon_exp));
      end
   end

   task automatic apply();
      rst = s_rst;
      bus.req0 = s_req[0]; bus.sclk0 = s_sclk[0]; bus.cs_n0 = s_csn[0]; bus.qdo0 = s_qdo[0]; bus.oe0 = s_oe[0];
      bus.req1 = s_req[1]; bus.sclk1 = s_sclk[1]; bus.cs_n1 = s_csn[1]; bus.qdo1 = s_qdo[1]; bus.oe1 = s_oe[1];
      bus.qdi  = s_qdi;
   endtask

   // One clock: drive staged inputs after the edge, then queue the predicted outputs.
   task automatic step();
      @(posedge clk);
      #1 apply();
      #1 sb.push_back(expect_now());
   endtask

   task automatic idle_inputs();
      for (int p = 0; p < 2; p++) begin
         s_req[p] = 1'b0; s_sclk[p] = 1'b0; s_csn[p] = 1'b1; s_qdo[p] = 4'h0; s_oe[p] = 4'h0;
      end
      s_qdi = 4'h0;
   endtask

   int  clk_after;
   bit  owned;

   initial begin
      s_rst = 1'b1;
      idle_inputs();
      apply();
      repeat (3) step();
      s_rst = 1'b0;
      repeat (4) step();

      // Simultaneous requests straight after reset: port 0 wins first.
      s_req[0] = 1'b1; s_req[1] = 1'b1;
      step();
      step();
      check("tie_gnt0", 32'(bus.gnt0), 32'd1);
      check("tie_gnt1", 32'(bus.gnt1), 32'd0);
      check("tie_owner", 32'(bus.owner), 32'd1);

      // Port 0 owns but idles; port 1 is not granted and scribbles on its pins.
      s_csn[1] = 1'b0; s_oe[1] = 4'hF; s_sclk[1] = 1'b1; s_qdi = 4'hA;
      step();
      check("ungranted_csn", 32'(bus.spi_csn), 32'd1);
      check("ungranted_oe", 32'(bus.oe), 32'd0);
      check("qdi_fan0", 32'(bus.qdi0), 32'hA);
      check("qdi_fan1", 32'(bus.qdi1), 32'hA);

      // Port 0 frame: pads follow port 0.
      s_csn[0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s_sclk[0] = i[0]; s_qdo[0] = 4'($urandom); s_oe[0] = 4'hF;
         s_sclk[1] = ~i[0]; s_csn[1] = i[0];
         step();
      end
      check("frame_oe", 32'(bus.oe), 32'hF);
      check("frame_csn", 32'(bus.spi_csn), 32'd0);

      // Dropping req mid-frame must not truncate it.
      s_req[0] = 1'b0; s_csn[1] = 1'b1; s_oe[1] = 4'h0;
      repeat (20) step();
      check("hold_while_csn_low", 32'(bus.gnt0), 32'd1);

      // Release, then the guard: port 1 granted GUARD+1 clocks after the release edge.
      s_csn[0] = 1'b1; s_oe[0] = 4'h0;
      step();
      clk_after = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         clk_after++;
         if (bus.gnt1) break;
      end
      check("guard_to_gnt1", 32'(clk_after), 32'(GUARD + 1));

      // Reset mid-frame while port 1 drives the bus.
      s_csn[1] = 1'b0; s_oe[1] = 4'hF; s_qdo[1] = 4'h5;
      repeat (3) step();
      check("pre_reset_oe", 32'(bus.oe), 32'hF);
      s_rst = 1'b1;
      step();
      check("async_rst_csn", 32'(bus.spi_csn), 32'd1);
      check("async_rst_oe", 32'(bus.oe), 32'd0);
      check("async_rst_gnt1", 32'(bus.gnt1), 32'd0);
      check("async_rst_owner", 32'(bus.owner), 32'd0);
      s_rst = 1'b0;
      idle_inputs();
      repeat (2) step();

      // Long hold by port 0 with port 1 waiting.
      s_req[0] = 1'b1; s_req[1] = 1'b1;
      step();
      step();
      s_csn[0] = 1'b0;
      repeat (150) step();
`ifdef SPI_ARB_TIMEOUT_EN
      check("timeout_fault", 32'(bus.fault), 32'd1);
      check("timeout_owner", 32'(bus.owner), 32'd2);
`else
      check("no_timeout_gnt0", 32'(bus.gnt0), 32'd1);
      check("no_timeout_fault", 32'(bus.fault), 32'd0);
`endif
      idle_inputs();
      repeat (10) step();

      // Randomized masters: frames of random length, withdrawn requests, junk on idle ports.
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            owned = (m_owner == p + 1);
            if (owned) begin
               if ($urandom_range(0, 3) == 0) s_csn[p] = ~s_csn[p];
               if ($urandom_range(0, 7) == 0)      s_req[p] = 1'b0;
               else if ($urandom_range(0, 7) == 0) s_req[p] = 1'b1;
            end else begin
               if ($urandom_range(0, 5) == 0) s_req[p] = ~s_req[p];
               s_csn[p] = ($urandom_range(0, 3) != 0);
            end
            s_sclk[p] = 1'($urandom);
            s_qdo[p]  = 4'($urandom);
            s_oe[p]   = 4'($urandom);
         end
         s_qdi = 4'($urandom);
         step();
      end

      repeat (2) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
